// File: rtl/sseg_mux_ctrl.sv
// Multiplexed seven-segment display controller with a double-buffered digit register.
// Build option: define SSEG_BRIGHTNESS_PWM_EN to gate each anode with a 16-level brightness PWM.
module sseg_mux_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_LOG2 = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] DATA,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   BLANK,
  input  logic [3:0]              BRIGHT,
  output logic [7:0]              SSEG_CA,
  output logic [NUM_DIGITS-1:0]   SSEG_AN,
  output logic                    FRAME_DONE,
  output logic                    PENDING
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [REFRESH_LOG2-1:0] presc;
  logic [IW-1:0]           idx;

  logic [4*NUM_DIGITS-1:0] shd_data, act_data;
  logic [NUM_DIGITS-1:0]   shd_dp, act_dp;
  logic [NUM_DIGITS-1:0]   shd_blank, act_blank;

  logic       slot_end, frame_end, guard, pwm_on;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_blank;
  logic [7:0] seg;
  logic [NUM_DIGITS-1:0] an_on;

  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h98;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign slot_end  = &presc;
  assign frame_end = slot_end && (idx == LAST_IDX);
  assign guard     = (presc == '0);

`ifdef SSEG_BRIGHTNESS_PWM_EN
  assign pwm_on = (presc[REFRESH_LOG2-1 -: 4] <= BRIGHT);
`else
  logic bright_unused;
  assign bright_unused = ^BRIGHT;
  assign pwm_on        = 1'b1;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
      end
    end
  end

  assign seg   = hex_decode(cur_nib);
  assign an_on = ~(NUM_DIGITS'(1) << idx);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (slot_end)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the shadow so it is never lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shd_data  <= '0;
      shd_dp    <= '0;
      shd_blank <= '1;
      act_data  <= '0;
      act_dp    <= '0;
      act_blank <= '1;
      PENDING   <= 1'b0;
    end else if (LOAD && frame_end) begin
      shd_data  <= DATA;
      shd_dp    <= DP;
      shd_blank <= BLANK;
      act_data  <= DATA;
      act_dp    <= DP;
      act_blank <= BLANK;
      PENDING   <= 1'b0;
    end else if (frame_end && PENDING) begin
      act_data  <= shd_data;
      act_dp    <= shd_dp;
      act_blank <= shd_blank;
      PENDING   <= 1'b0;
    end else if (LOAD) begin
      shd_data  <= DATA;
      shd_dp    <= DP;
      shd_blank <= BLANK;
      PENDING   <= 1'b1;
    end
  end

  // The first cycle of each slot keeps anodes off so the previous digit cannot ghost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SSEG_CA    <= 8'hFF;
      SSEG_AN    <= '1;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= frame_end;
      if (cur_blank) begin
        SSEG_CA <= 8'hFF;
        SSEG_AN <= '1;
      end else begin
        SSEG_CA <= {seg[7] & ~cur_dp, seg[6:0]};
        SSEG_AN <= (guard || !pwm_on) ? '1 : an_on;
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// Directed bench for sseg_mux_ctrl at NUM_DIGITS=4, REFRESH_LOG2=4 (64-cycle frames).
// Brightness expectations follow SSEG_BRIGHTNESS_PWM_EN as the RTL was built.
module tb_sseg_mux_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] DATA = '0;
  logic [3:0]  DP = '0;
  logic [3:0]  BLANK = '0;
  logic [3:0]  BRIGHT = 4'hF;
  logic [7:0]  SSEG_CA;
  logic [3:0]  SSEG_AN;
  logic        FRAME_DONE;
  logic        PENDING;

  int n_checks = 0;
  int n_pass   = 0;

  sseg_mux_ctrl #(.NUM_DIGITS(4), .REFRESH_LOG2(4)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA(DATA), .DP(DP), .BLANK(BLANK),
    .BRIGHT(BRIGHT), .SSEG_CA(SSEG_CA), .SSEG_AN(SSEG_AN),
    .FRAME_DONE(FRAME_DONE), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Leaves the bench at the negedge where FRAME_DONE is high.
  task automatic sync_frame(input string tag);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!FRAME_DONE && n < 200);
    if (!FRAME_DONE) check(tag, FRAME_DONE, 1);
  endtask

  // Counts cycles to the next FRAME_DONE and whether the display stayed dark throughout.
  task automatic measure_frame(output int n, output logic dark);
    n = 0;
    dark = 1'b1;
    do begin
      tick(1);
      n++;
      if (SSEG_AN !== 4'hF || SSEG_CA !== 8'hFF || PENDING !== 1'b0) dark = 1'b0;
    end while (!FRAME_DONE && n < 200);
  endtask

  initial begin
    int n;
    logic dark;
    logic [15:0] lit_mask;
    logic [15:0] lit_exp;

    tick(3);
    check("rst_an", SSEG_AN, 4'hF);
    check("rst_ca", SSEG_CA, 8'hFF);
    check("rst_fd", FRAME_DONE, 0);
    check("rst_pend", PENDING, 0);

    RST = 1'b0;
    measure_frame(n, dark);
    check("first_frame_len", n, 64);
    check("first_frame_dark", dark, 1);
    measure_frame(n, dark);
    check("frame_period", n, 64);
    check("idle_frame_dark", dark, 1);

    // Mid-frame load is held in the shadow until the boundary.
    tick(5);
    DATA = 16'h1234; DP = 4'h0; BLANK = 4'h0; BRIGHT = 4'hF; LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    check("pend_set", PENDING, 1);
    tick(57);
    check("pend_hold", PENDING, 1);
    check("fd_before_bnd", FRAME_DONE, 0);
    tick(1);
    check("fd_at_bnd", FRAME_DONE, 1);
    check("pend_clr", PENDING, 0);
    tick(1);
    check("d0_guard_an", SSEG_AN, 4'hF);
    check("d0_guard_ca", SSEG_CA, 8'h99);
    tick(1);
    check("d0_an", SSEG_AN, 4'hE);
    check("d0_ca", SSEG_CA, 8'h99);
    tick(16);
    check("d1_an", SSEG_AN, 4'hD);
    check("d1_ca", SSEG_CA, 8'hB0);
    tick(16);
    check("d2_an", SSEG_AN, 4'hB);
    check("d2_ca", SSEG_CA, 8'hA4);
    tick(16);
    check("d3_an", SSEG_AN, 4'h7);
    check("d3_ca", SSEG_CA, 8'hF9);

    // Brightness: record which cycles of digit 0's slot have the anode lit.
    BRIGHT = 4'h3;
    sync_frame("sync_pwm");
    tick(1);
    lit_mask = '0;
    for (int c = 0; c < 16; c++) begin
      lit_mask[c] = (SSEG_AN == 4'hE);
      tick(1);
    end
`ifdef SSEG_BRIGHTNESS_PWM_EN
    lit_exp = 16'h000E;
`else
    lit_exp = 16'hFFFE;
`endif
    check("pwm_lit_mask", lit_mask, lit_exp);
    BRIGHT = 4'hF;

    // Load exactly in the boundary cycle goes straight to the active register.
    sync_frame("sync_bnd");
    tick(63);
    DATA = 16'h00F0; DP = 4'b0010; BLANK = 4'h0; LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    check("bnd_fd", FRAME_DONE, 1);
    check("bnd_pend", PENDING, 0);
    tick(2);
    check("bnd_pend_after", PENDING, 0);
    check("bnd_d0_an", SSEG_AN, 4'hE);
    check("bnd_d0_ca", SSEG_CA, 8'hC0);
    tick(16);
    check("bnd_d1_an", SSEG_AN, 4'hD);
    check("bnd_d1_ca", SSEG_CA, 8'h0E);

    // Blank mask on digit 3.
    sync_frame("sync_blank");
    tick(5);
    DATA = 16'h8888; DP = 4'h0; BLANK = 4'b1000; LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    sync_frame("sync_blank2");
    tick(2);
    check("blk_d0_an", SSEG_AN, 4'hE);
    check("blk_d0_ca", SSEG_CA, 8'h80);
    tick(32);
    check("blk_d2_an", SSEG_AN, 4'hB);
    check("blk_d2_ca", SSEG_CA, 8'h80);
    tick(15);
    dark = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (SSEG_AN !== 4'hF || SSEG_CA !== 8'hFF) dark = 1'b0;
      tick(1);
    end
    check("blk_d3_dark", dark, 1);

    // Reset pulse while a shadow update is pending in slot 2.
    sync_frame("sync_rst");
    tick(40);
    DATA = 16'h5555; BLANK = 4'h0; LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    check("rst_pre_pend", PENDING, 1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_an", SSEG_AN, 4'hF);
    check("rst_async_ca", SSEG_CA, 8'hFF);
    check("rst_async_pend", PENDING, 0);
    @(negedge CLK);
    RST = 1'b0;
    measure_frame(n, dark);
    check("post_rst_frame_len", n, 64);
    check("post_rst_dark", dark, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
